// File: rtl/a2d_spi_resp.sv
// rtl/a2d_spi_resp.sv - SPI responder for the A2D link (optional frame counter: A2D_FRAME_CNT_EN)
module a2d_spi_resp #(
    parameter int DATA_W      = 12,
    parameter int FRAME_W     = 16,
    parameter int CH_W        = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           SS_n,
    input  logic                           SCLK,
    input  logic                           MOSI,
    output logic                           MISO,
    input  logic [(2**CH_W)*DATA_W-1:0]    ch_data,
    output logic [CH_W-1:0]                cur_chnnl,
    output logic                           frame_done,
    output logic                           frame_err,
`ifdef A2D_FRAME_CNT_EN
    output logic [15:0]                    frame_cnt,
`endif
    output logic                           busy
);

    // bit_cnt must reach FRAME_W+1 so an overrun frame is distinguishable
    localparam int CNT_W = $clog2(FRAME_W + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_W + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [SYNC_STAGES-1:0]  ss_sync;
    logic [SYNC_STAGES-1:0]  sclk_sync;
    logic [SYNC_STAGES-1:0]  mosi_sync;
    logic                    ss_prev;
    logic                    sclk_prev;
    logic                    ss_s;
    logic                    sclk_s;
    logic                    mosi_s;
    logic                    ss_fall;
    logic                    ss_rise;
    logic                    sclk_rise;
    logic                    sclk_fall;
    logic                    frame_ok;
    logic [FRAME_W-1:0]      tx_shft;
    logic [FRAME_W-1:0]      rx_shft;
    logic [CNT_W-1:0]        bit_cnt;
    logic [DATA_W-1:0]       sample;
    logic                    unused_rx;

    assign ss_s   = ss_sync[SYNC_STAGES-1];
    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    assign ss_fall   = ss_prev & ~ss_s;
    assign ss_rise   = ~ss_prev & ss_s;
    assign sclk_rise = ~sclk_prev & sclk_s;
    assign sclk_fall = sclk_prev & ~sclk_s;

    // A frame is valid only if exactly FRAME_W rising edges were seen
    assign frame_ok = (state == SHIFT) && ss_rise && (bit_cnt == CNT_FULL);

    assign sample = ch_data[cur_chnnl*DATA_W +: DATA_W];
    assign busy   = (state == SHIFT);
    assign MISO   = (state == SHIFT) ? tx_shft[FRAME_W-1] : 1'b0;

    // Only the channel field of the received frame is used
    assign unused_rx = ^{rx_shft[FRAME_W-1:FRAME_W-2], rx_shft[FRAME_W-3-CH_W:0]};

    // Input synchronizers plus one history flop per line for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_sync   <= '1;
            sclk_sync <= '0;
            mosi_sync <= '0;
            ss_prev   <= 1'b1;
            sclk_prev <= 1'b0;
        end else begin
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS_n};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
            ss_prev   <= ss_s;
            sclk_prev <= sclk_s;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: a frame spans from SS_n fall to SS_n rise
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ss_fall) state_nxt = SHIFT;
            SHIFT:   if (ss_rise) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Shift datapath, bit counting and frame-end bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_shft    <= '0;
            rx_shft    <= '0;
            bit_cnt    <= '0;
            cur_chnnl  <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (ss_fall) begin
                        // Snapshot the sample so later ch_data changes cannot corrupt the frame
                        tx_shft <= {{(FRAME_W-DATA_W){1'b0}}, sample};
                        bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    // SS_n rise takes priority over any coincident SCLK edge
                    if (ss_rise) begin
                        if (bit_cnt == CNT_FULL) begin
                            cur_chnnl  <= rx_shft[FRAME_W-3 -: CH_W];
                            frame_done <= 1'b1;
                        end else begin
                            frame_err  <= 1'b1;
                        end
                    end else begin
                        if (sclk_rise) begin
                            rx_shft <= {rx_shft[FRAME_W-2:0], mosi_s};
                            if (bit_cnt != CNT_SAT) begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                        // The first falling edge precedes any rise only in malformed frames
                        if (sclk_fall && (bit_cnt != '0)) begin
                            tx_shft <= {tx_shft[FRAME_W-2:0], 1'b0};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef A2D_FRAME_CNT_EN
    // Count valid frames only, wrapping naturally at 16 bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (frame_ok) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_a2d_spi_resp.sv
// tb/tb_a2d_spi_resp.sv - randomized self-checking bench for a2d_spi_resp
module tb_a2d_spi_resp;

    logic        clk;
    logic        rst;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;
    logic [95:0] ch_data;
    logic [2:0]  cur_chnnl;
    logic        frame_done;
    logic        frame_err;
    logic        busy;
`ifdef A2D_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    int          n_chk;
    int          n_pass;
    int          done_cnt;
    int          err_cnt;
    int          ref_ch;
    logic [15:0] ref_cnt;
    int          chg_en;
    logic [11:0] chg_val;

    a2d_spi_resp dut (
        .clk        (clk),
        .rst        (rst),
        .SS_n       (SS_n),
        .SCLK       (SCLK),
        .MOSI       (MOSI),
        .MISO       (MISO),
        .ch_data    (ch_data),
        .cur_chnnl  (cur_chnnl),
        .frame_done (frame_done),
        .frame_err  (frame_err),
`ifdef A2D_FRAME_CNT_EN
        .frame_cnt  (frame_cnt),
`endif
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done) done_cnt++;
        if (frame_err)  err_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bit(input logic b, output logic m);
        MOSI = b;
        wait_clk($urandom_range(4, 6));
        SCLK = 1'b1;
        m = MISO;
        wait_clk($urandom_range(4, 6));
        SCLK = 1'b0;
    endtask

    task automatic spi_frame(input logic [15:0] w, input int nbits,
                             output logic [15:0] r, output logic bmid);
        logic m;
        SS_n = 1'b0;
        wait_clk(4);
        bmid = busy;
        r = '0;
        for (int i = 0; i < nbits; i++) begin
            spi_bit((i < 16) ? w[15-i] : 1'b0, m);
            if (i < 16) r[15-i] = m;
            if (chg_en != 0 && i == 5) ch_data[ref_ch*12 +: 12] = chg_val;
        end
        wait_clk(4);
        SS_n = 1'b1;
    endtask

    // Reference: each frame returns the sample of the channel chosen by the previous valid frame
    task automatic do_frame(input logic [15:0] w, input int nbits);
        logic [15:0] exp_w;
        logic [15:0] r;
        logic [15:0] mask;
        logic        bmid;
        int          d0;
        int          e0;
        exp_w = {4'h0, ch_data[ref_ch*12 +: 12]};
        d0 = done_cnt;
        e0 = err_cnt;
        spi_frame(w, nbits, r, bmid);
        wait_clk(8);
        mask = (nbits >= 16) ? 16'hFFFF : ~(16'hFFFF >> nbits);
        chk("miso_word", r & mask, exp_w & mask);
        chk("busy_mid", bmid, 1);
        if (nbits == 16) begin
            ref_ch = int'(w[13:11]);
            ref_cnt = ref_cnt + 16'd1;
            chk("frame_done", done_cnt - d0, 1);
            chk("frame_err", err_cnt - e0, 0);
        end else begin
            chk("frame_done", done_cnt - d0, 0);
            chk("frame_err", err_cnt - e0, 1);
        end
        chk("cur_chnnl", cur_chnnl, ref_ch);
        chk("busy_idle", busy, 0);
        chk("miso_idle", MISO, 0);
`ifdef A2D_FRAME_CNT_EN
        chk("frame_cnt", frame_cnt, ref_cnt);
`endif
    endtask

    initial begin
        logic m;
        int   d0;
        int   sel;
        int   nb;
        n_chk = 0; n_pass = 0; done_cnt = 0; err_cnt = 0;
        ref_ch = 0; ref_cnt = '0; chg_en = 0; chg_val = '0;
        rst = 1'b1; SS_n = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
        ch_data = {$urandom, $urandom, $urandom};

        // Reset then idle
        wait_clk(3);
        chk("rst_miso", MISO, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        wait_clk(10);
        chk("idle_miso", MISO, 0);
        chk("idle_cur", cur_chnnl, 0);
        chk("idle_busy", busy, 0);
        chk("idle_pulses", done_cnt + err_cnt, 0);

        // Channel select, then read back
        ch_data[3*12 +: 12] = 12'hABC;
        do_frame(16'h1800, 16);
        chk("sel_ch3", cur_chnnl, 3);
        ch_data[0 +: 12] = 12'h321;
        do_frame(16'h0000, 16);

        // Pipeline order
        for (int n = 0; n < 8; n++) ch_data[n*12 +: 12] = 12'h100 + 12'(n);
        do_frame(16'h0000, 16);
        do_frame(16'h3800, 16);
        do_frame(16'h1000, 16);
        do_frame(16'h0000, 16);

        // Short frame keeps the previous channel
        ref_ch = ref_ch;
        do_frame(16'h2800, 9);
        do_frame(16'h1000, 16);

        // Snapshot at SS_n fall
        ch_data[ref_ch*12 +: 12] = 12'h555;
        chg_en = 1; chg_val = 12'hAAA;
        do_frame(16'h1000, 16);
        chg_en = 0;

        // Randomized frames including short and overrun lengths
        for (int k = 0; k < 30; k++) begin
            ch_data = {$urandom, $urandom, $urandom};
            sel = $urandom_range(0, 7);
            nb = (sel == 0) ? 9 : (sel == 1) ? $urandom_range(0, 17) : 16;
            chg_en = $urandom_range(0, 1);
            chg_val = 12'($urandom);
            do_frame(16'($urandom), nb);
            chg_en = 0;
        end

        // Async reset mid-frame
        ch_data[ref_ch*12 +: 12] = 12'h0FF;
        SS_n = 1'b0;
        wait_clk(4);
        for (int i = 0; i < 8; i++) spi_bit(1'b0, m);
        wait_clk(5);
        chk("miso_pre_rst", MISO, 1);
        d0 = done_cnt;
        rst = 1'b1;
        SS_n = 1'b1;
        #1;
        chk("rst_mid_miso", MISO, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_cur", cur_chnnl, 0);
        wait_clk(3);
        rst = 1'b0;
        wait_clk(8);
        chk("rst_mid_done", done_cnt - d0, 0);
        ref_ch = 0;
        ref_cnt = '0;
        do_frame(16'h2000, 16);

`ifdef A2D_FRAME_CNT_EN
        do_frame(16'h0800, 16);
        do_frame(16'h1800, 16);
        chk("cnt_three", frame_cnt, 3);
        force dut.frame_cnt = 16'hFFFF;
        wait_clk(1);
        release dut.frame_cnt;
        ref_cnt = 16'hFFFF;
        do_frame(16'h0000, 16);
        chk("cnt_wrap", frame_cnt, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
